// File: rtl/usart_rx_param_if.sv
// usart_rx_param_if: serial-in / word-out bundle of the parametrised UART receiver.
//   rx_data     serial line into the receiver (idle high)
//   rx_data_o   last received word, LSB received first
//   rx_valid    one-cycle strobe marking a new rx_data_o
//   rx_busy     high while a frame is being received
//   frame_err   stop bit sampled low in the last frame
//   parity_err  parity mismatch in the last frame
// master: receiver side; slave: line driver / word consumer side.
`timescale 1ns/1ps
interface usart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx_data;
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        input  rx_data,
        output rx_data_o, rx_valid, rx_busy, frame_err, parity_err
    );

    modport slave (
        output rx_data,
        input  rx_data_o, rx_valid, rx_busy, frame_err, parity_err
    );
endinterface

// File: rtl/usart_rx_param.sv
// usart_rx_param: parametrised UART receiver with 3-sample majority voting,
// false-start rejection and framing/parity error reporting.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    usart_rx_param_if.master: rx_data in; rx_data_o, rx_valid,
//          rx_busy, frame_err, parity_err out (all registered)
// Optional feature: define USART_RX_PARITY_EN to expect one parity bit after
// the data (even, or odd when PARITY_ODD = 1). Without it parity_err is 0.
`timescale 1ns/1ps
module usart_rx_param #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    usart_rx_param_if.master  bus
);

    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    // Elaboration-time guard against unsupported parameter sets.
    if (CLK_DIV < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1) begin : g_bad_cfg
        $error("usart_rx_param: illegal parameter set");
    end

`ifdef USART_RX_PARITY_EN
    localparam logic PAR_ODD = 1'(PARITY_ODD);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 samp_a_q, samp_a_d;
    logic                 samp_b_q, samp_b_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 ferr_q, ferr_d;
`ifdef USART_RX_PARITY_EN
    logic                 perr_acc_q, perr_acc_d;
    logic                 perr_q, perr_d;
`endif

    logic sync1_q, sync2_q, sync3_q;
    logic fall, at_last, at_dec, vote;

    // Two-FF synchronizer plus one history FF; reset high so the line reads idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx_data;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            samp_a_q   <= 1'b1;
            samp_b_q   <= 1'b1;
            shift_q    <= '0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef USART_RX_PARITY_EN
            perr_acc_q <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            samp_a_q   <= samp_a_d;
            samp_b_q   <= samp_b_d;
            shift_q    <= shift_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ferr_q     <= ferr_d;
`ifdef USART_RX_PARITY_EN
            perr_acc_q <= perr_acc_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign fall    = sync3_q & ~sync2_q;
    assign at_last = (cnt_q == CNT_LAST);
    assign at_dec  = (cnt_q == CNT_DEC);
    // Majority of the samples at HALF-1, HALF and the live one at HALF+1.
    assign vote    = (samp_a_q & samp_b_q) | (samp_a_q & sync2_q) | (samp_b_q & sync2_q);

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        samp_a_d   = samp_a_q;
        samp_b_d   = samp_b_q;
        shift_d    = shift_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        ferr_d     = ferr_q;
`ifdef USART_RX_PARITY_EN
        perr_acc_d = perr_acc_q;
        perr_d     = perr_q;
`endif

        // Bit-time counter and early vote samples run in every non-idle state.
        if (state_q != S_IDLE) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_S0) samp_a_d = sync2_q;
            if (cnt_q == CNT_S1) samp_b_d = sync2_q;
        end

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    bit_d      = '0;
                    stop_d     = 1'b0;
                    ferr_acc_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef USART_RX_PARITY_EN
                    perr_acc_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (at_dec && vote) begin
                    // False start: the line was back high mid-bit.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (at_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (at_dec) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (at_last) begin
                    if (bit_q == BIT_LAST) begin
`ifdef USART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef USART_RX_PARITY_EN
            S_PARITY: begin
                if (at_dec)  perr_acc_d = vote ^ (^shift_q) ^ PAR_ODD;
                if (at_last) state_d    = S_STOP;
            end
`endif
            S_STOP: begin
                if (at_dec && stop_q == STOP_LAST) begin
                    // Deliver at mid last stop bit so the next start edge is caught.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    ferr_d  = ferr_acc_q | ~vote;
`ifdef USART_RX_PARITY_EN
                    perr_d  = perr_acc_q;
`endif
                end else begin
                    if (at_dec && !vote) ferr_acc_d = 1'b1;
                    if (at_last)         stop_d     = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.rx_data_o = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.rx_busy   = busy_q;
    assign bus.frame_err = ferr_q;
`ifdef USART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_usart_rx_param.sv
// tb_usart_rx_param: scoreboard bench for usart_rx_param. Stimulus tasks build
// serial frames, push the expected word/flags/strobe cycle into a queue, and a
// monitor pops and compares whenever rx_valid is seen.
`timescale 1ns/1ps
module tb_usart_rx_param;

    localparam int CLK_DIV    = 434;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
    localparam int HALF       = CLK_DIV / 2;
`ifdef USART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + DATA_BITS + P + STOP_BITS;
    localparam int VOFF  = (NBITS - 1) * CLK_DIV + HALF + 2;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        int         cycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [7:0] last_data = 8'h00;
    exp_t exp_q[$];

    usart_rx_param_if #(.DATA_BITS(DATA_BITS)) bus ();

    usart_rx_param #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rx_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rx_data_o",  32'(bus.rx_data_o), 32'(e.data));
                check("frame_err",  32'(bus.frame_err), 32'(e.ferr));
                check("parity_err", 32'(bus.parity_err), 32'(e.perr));
                check("valid_cycle", 32'(cyc), 32'(e.cycle));
                last_data = e.data;
            end
        end
    end

    task automatic idle(input int n);
        bus.rx_data = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one full frame; called at a negedge. spike_bit < 0 means no spike.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input bit stop_low,
                              input int spike_bit, input int spike_pos);
        logic bits [NBITS];
        exp_t e;
        int   c, rel;
        logic lvl;
        bits[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) bits[1 + i] = d[i];
        if (P == 1) bits[1 + DATA_BITS] = pbit;
        for (int i = 0; i < STOP_BITS; i++) bits[1 + DATA_BITS + P + i] = ~stop_low;
        c = cyc;
        e.data  = d;
        e.ferr  = stop_low;
        e.perr  = (P == 1) ? (pbit != ((^d) ^ 1'(PARITY_ODD))) : 1'b0;
        e.cycle = c + 3 + VOFF;
        exp_q.push_back(e);
        for (int b = 0; b < NBITS; b++) begin
            for (int j = 0; j < CLK_DIV; j++) begin
                lvl = bits[b];
                if (b == spike_bit && j == spike_pos) lvl = ~lvl;
                bus.rx_data = lvl;
                @(negedge clk);
                rel = cyc - (c + 3);
                if (rel == -1 || rel == 0 || rel == VOFF - 1 || rel == VOFF)
                    check("rx_busy_frame", 32'(bus.rx_busy), 32'(rel >= 0 && rel < VOFF));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int c, rel, gap, sb, sp;
        bit sl;

        // Reset values.
        bus.rx_data = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_rx_data_o", 32'(bus.rx_data_o), 32'd0);
        check("rst_rx_valid",  32'(bus.rx_valid), 32'd0);
        check("rst_rx_busy",   32'(bus.rx_busy), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        rst_n = 1'b1;
        idle(20);

        // Clean 8N1 frame.
        send_frame(8'hA5, ^8'hA5, 1'b0, -1, 0);
        idle(10);

        // 100-cycle low glitch: false start.
        c = cyc;
        for (int j = 0; j < 2 * CLK_DIV; j++) begin
            bus.rx_data = (j < 100) ? 1'b0 : 1'b1;
            @(negedge clk);
            rel = cyc - (c + 3);
            if (rel == -1 || rel == 0 || rel == HALF + 1 || rel == HALF + 2)
                check("rx_busy_glitch", 32'(bus.rx_busy), 32'(rel >= 0 && rel <= HALF + 1));
        end
        check("glitch_data_held", 32'(bus.rx_data_o), 32'(last_data));

        // One-cycle spike at mid data bit 2.
        send_frame(8'h3C, ^8'h3C, 1'b0, 3, HALF);
        idle(10);

        // Break: 0x00 with low stop, line held low 3 more bit times.
        send_frame(8'h00, 1'b0, 1'b1, -1, 0);
        bus.rx_data = 1'b0;
        repeat (3 * CLK_DIV) @(negedge clk);
        check("break_busy_low", 32'(bus.rx_busy), 32'd0);
        idle(CLK_DIV);

`ifdef USART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b0, -1, 0);
        idle(10);
        send_frame(8'h07, 1'b1, 1'b0, -1, 0);
        idle(10);
`endif

        // Back-to-back frames, then reset during data bit 4 of a third.
        send_frame(8'h55, ^8'h55, 1'b0, -1, 0);
        send_frame(8'hAA, ^8'hAA, 1'b0, -1, 0);
        d = 8'h6B;
        for (int b = 0; b < 6; b++) begin
            for (int j = 0; j < ((b == 5) ? HALF : CLK_DIV); j++) begin
                bus.rx_data = (b == 0) ? 1'b0 : d[b - 1];
                @(negedge clk);
            end
        end
        check("busy_before_reset", 32'(bus.rx_busy), 32'd1);
        rst_n = 1'b0;
        bus.rx_data = 1'b1;
        #1;
        check("mid_rst_busy",  32'(bus.rx_busy), 32'd0);
        check("mid_rst_data",  32'(bus.rx_data_o), 32'd0);
        check("mid_rst_ferr",  32'(bus.frame_err), 32'd0);
        check("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
        last_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        check("post_rst_busy", 32'(bus.rx_busy), 32'd0);
        check("post_rst_data", 32'(bus.rx_data_o), 32'd0);
        check("post_rst_perr", 32'(bus.parity_err), 32'd0);

        // Random frames with random gaps, single-sample spikes and stop errors.
        for (int k = 0; k < 5; k++) begin
            d   = 8'($urandom);
            sl  = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(sl ? 4 : 0, 40);
            sb  = $urandom_range(0, NBITS - 1);
            sp  = HALF - 1 + $urandom_range(0, 2);
            if (gap > 0) idle(gap);
            send_frame(d, (^d) ^ 1'(PARITY_ODD), sl, sb, sp);
            if (sl) idle(4);
        end
        idle(20);

        check("pending_expected", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
